pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage, replacing the plain PC register. It holds the fetch PC and computes the next PC from four sources, in priority order: redirect, return-address pop, branch/call target, and sequential increment. It also contains a circular return-address stack (RAS) with overflow and underflow reporting. It sits between the branch/exception logic and the instruction memory address port.

## Interface
- WIDTH, 32, PC and target width in bits
- RESET_PC, 0, value loaded into PC on reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 8, RAS entries; must be a power of two, at least 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- Stall  input  1  freezes PC and RAS unless Redirect is asserted
- Redirect  input  1  mispredict/exception redirect; highest priority
- RedirectTarget  input  WIDTH  target used when Redirect is asserted
- Branch  input  1  taken branch/jump to BranchTarget
- Call  input  1  jump to BranchTarget and push PC+INC onto the RAS
- Ret  input  1  pop the RAS and jump to the popped address
- BranchTarget  input  WIDTH  target for Branch and Call
- PC  output  WIDTH  current fetch PC (registered)
- PCPlus  output  WIDTH  PC+INC (combinational)
- RasEmpty  output  1  RAS count equals 0 (combinational from state)
- RasOverflow  output  1  registered one-cycle pulse: a push overwrote the oldest entry
- RasUnderflow  output  1  registered one-cycle pulse: a Ret was taken with the RAS empty

## Operation
- Next-PC priority (evaluated every cycle):
  1. Redirect: load RedirectTarget. This applies even while Stall is asserted. RAS is unchanged.
  2. Stall: hold PC and RAS. Branch, Call and Ret are ignored.
  3. Ret: if RAS is non-empty, load the top entry, decrement the pointer and count. If RAS is empty, load PCPlus and pulse RasUnderflow.
  4. Call: load BranchTarget and push PCPlus.
  5. Branch: load BranchTarget.
  6. Otherwise: load PCPlus.
- If Call and Ret are asserted together, Ret wins and Call is dropped. No push occurs.
- If Call and Branch are asserted together, Call applies; the target is the same BranchTarget.
- RAS storage:
  - RAS_DEPTH entries of WIDTH bits, with a top pointer of log2(RAS_DEPTH) bits and a count of 0..RAS_DEPTH.
  - Push: pointer increments modulo RAS_DEPTH, then the entry is written at the new pointer.
  - Count saturates at RAS_DEPTH. A push while full overwrites the oldest entry and pulses RasOverflow.
  - Pop reads the entry at the pointer, then the pointer decrements modulo RAS_DEPTH.
- Arithmetic: PCPlus = PC + INC, truncated to WIDTH bits (wraps modulo 2^WIDTH). No alignment checks.
- Reset (rst low, asynchronous):
  - PC = RESET_PC; pointer = 0; count = 0.
  - RasOverflow = 0; RasUnderflow = 0.
  - RAS data contents are don't-care.

## Timing
- Single-cycle update: inputs sampled at edge N appear on PC after edge N.
- PCPlus and RasEmpty follow PC and count with no added latency.
- Pulse timing:
  - RasOverflow and RasUnderflow are high for exactly the cycle after the triggering edge.
  - Both are cleared on the next edge unless the event repeats.
- Reset mid-operation: outputs go to reset values immediately, without waiting for a clock edge. The first update occurs on the first rising edge after rst deasserts.
- A Ret on the cycle immediately after a Call returns the just-pushed address (write-then-read through registered state; no bypass is needed).

## Test plan
- Reset / sequential: RESET_PC=0x100, release rst, idle 3 cycles -> PC = 0x100, 0x104, 0x108, 0x10C; RasEmpty=1.
- Stall vs. redirect: at PC=0x10C, assert Stall for 2 cycles -> PC holds 0x10C. Then assert Stall together with Redirect, RedirectTarget=0x2000 -> PC=0x2000 on the next cycle.
- Call/return nesting: at PC=0x40, Call to 0x800. At 0x800, Call to 0x900. Then Ret, then Ret -> PC = 0x800, 0x900, 0x804, 0x44. RasEmpty=1 at the end. Repeat with Call and Ret asserted together -> Ret wins, no push.
- Overflow (RAS_DEPTH=4): 5 Calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40 -> RasOverflow pulses once on the 5th push. Four Rets then return 0x44, 0x34, 0x24, 0x14; 0x4 is lost.
- Underflow: Ret with RAS empty at PC=0x500 -> PC=0x504 and RasUnderflow high for 1 cycle. Count stays 0.
- Wrap and async reset:
  - PC=0xFFFFFFFC, idle -> PC=0x00000000.
  - Assert rst between clock edges -> PC=RESET_PC before the next edge. A pending Call is discarded.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with a circular return-address stack.
//
// The next PC comes from one of these sources, highest priority first:
//   Redirect > Stall (hold) > Ret (pop) > Call (push) > Branch > sequential
//
// Parameters:
//   WIDTH      PC and target width in bits
//   RESET_PC   value loaded into PC on reset
//   INC        sequential increment in bytes
//   RAS_DEPTH  RAS entries; must be a power of two, at least 2
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   rst             asynchronous active-low reset
//   Stall           hold PC and RAS unless Redirect is asserted
//   Redirect        load RedirectTarget; overrides everything else
//   RedirectTarget  redirect target
//   Branch          taken branch to BranchTarget
//   Call            jump to BranchTarget and push PCPlus
//   Ret             pop the RAS and jump to the popped address
//   BranchTarget    target for Branch and Call
//   PC              registered fetch PC
//   PCPlus          PC + INC, combinational, wraps modulo 2^WIDTH
//   RasEmpty        RAS count is zero
//   RasOverflow     one-cycle pulse: a push overwrote the oldest entry
//   RasUnderflow    one-cycle pulse: a Ret was taken with the RAS empty
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectTarget,
  input  logic             Branch,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] BranchTarget,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus,
  output logic             RasEmpty,
  output logic             RasOverflow,
  output logic             RasUnderflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] IncW = WIDTH'(INC);
  localparam logic [PW:0] CntFull = (PW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;

  // Return-address storage; contents are not reset.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign PCPlus       = pc_q + IncW;
  assign PC           = pc_q;
  assign RasEmpty     = (cnt_q == '0);
  assign RasOverflow  = ovf_q;
  assign RasUnderflow = unf_q;

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
    if (Redirect) begin
      pc_d = RedirectTarget;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (Ret) begin
      // Ret beats Call: a simultaneous Call is dropped without a push.
      if (cnt_q != '0) begin
        pc_d  = ras_q[ptr_q];
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - (PW + 1)'(1);
      end else begin
        pc_d  = PCPlus;
        unf_d = 1'b1;
      end
    end else if (Call) begin
      pc_d  = BranchTarget;
      push  = 1'b1;
      ptr_d = ptr_q + PW'(1);
      // When full the new entry lands on the oldest slot; count stays saturated.
      if (cnt_q == CntFull) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PW + 1)'(1);
      end
    end else if (Branch) begin
      pc_d = BranchTarget;
    end else begin
      pc_d = PCPlus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Written at the incremented pointer so a following pop reads it back.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[ptr_d] <= PCPlus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        branch = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ras_underflow;

  int errors = 0;
  int checks = 0;

  pc_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h100),
    .INC      (4),
    .RAS_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Stall         (stall),
    .Redirect      (redirect),
    .RedirectTarget(redirect_target),
    .Branch        (branch),
    .Call          (call),
    .Ret           (ret),
    .BranchTarget  (branch_target),
    .PC            (pc),
    .PCPlus        (pc_plus),
    .RasEmpty      (ras_empty),
    .RasOverflow   (ras_overflow),
    .RasUnderflow  (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect = 0; branch = 0; call = 0; ret = 0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    idle_inputs();
    redirect = 1; redirect_target = t;
    step();
    redirect = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'h104, 32'h108, 32'h10C};
    idle_inputs();
    repeat (2) step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h100); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
    checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin errors++;
      $display("FAIL reset_pulses: got ovf=%b unf=%b want 0 0", ras_overflow, ras_underflow); end
    @(negedge clk); rst = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc !== exp_seq[i]) begin errors++; $display("FAIL seq%0d: got %h want %h", i, pc, exp_seq[i]); end
      if (i < 2) step();
    end
    checks++; if (pc_plus !== 32'h110) begin errors++; $display("FAIL seq_pcplus: got %h want %h", pc_plus, 32'h110); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL seq_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_stall();
    idle_inputs();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc !== 32'h10C) begin errors++; $display("FAIL stall%0d: got %h want %h", i, pc, 32'h10C); end
    end
    redirect = 1; redirect_target = 32'h2000;
    step();
    checks++; if (pc !== 32'h2000) begin errors++; $display("FAIL stall_redirect: got %h want %h", pc, 32'h2000); end
    idle_inputs();
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h800, 32'h900, 32'h804, 32'h44};
    redirect_to(32'h40);
    call = 1; branch_target = 32'h800; step();
    checks++; if (pc !== exp_pc[0]) begin errors++; $display("FAIL call0: got %h want %h", pc, exp_pc[0]); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call0_empty: got %b want 0", ras_empty); end
    branch_target = 32'h900; step();
    checks++; if (pc !== exp_pc[1]) begin errors++; $display("FAIL call1: got %h want %h", pc, exp_pc[1]); end
    call = 0; ret = 1;
    for (int i = 2; i < 4; i++) begin
      step();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL ret%0d: got %h want %h", i - 2, pc, exp_pc[i]); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
    // Call and Ret together: Ret pops, Call is dropped.
    redirect_to(32'h40);
    call = 1; branch_target = 32'h800; step();
    ret = 1; branch_target = 32'h900; step();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL callret_pc: got %h want %h", pc, 32'h44); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL callret_empty: got %b want 1", ras_empty); end
    call = 0; step();
    checks++; if (pc !== 32'h48 || ras_underflow !== 1'b1) begin errors++;
      $display("FAIL callret_nopush: got pc=%h unf=%b want 48 1", pc, ras_underflow); end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};
    for (int i = 0; i < 5; i++) begin
      redirect_to(32'(i * 16));
      call = 1; branch_target = 32'h1000; step();
      call = 0;
      checks++; if (ras_overflow !== (i == 4)) begin errors++;
        $display("FAIL ovf_push%0d: got %b want %b", i, ras_overflow, (i == 4)); end
    end
    step();
    checks++; if (ras_overflow !== 1'b0 || pc !== 32'h1004) begin errors++;
      $display("FAIL ovf_clear: got ovf=%b pc=%h want 0 1004", ras_overflow, pc); end
    ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pc !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_ret[i]); end
      checks++; if (ras_empty !== (i == 3)) begin errors++;
        $display("FAIL ovf_empty%0d: got %b want %b", i, ras_empty, (i == 3)); end
    end
    idle_inputs();
  endtask

  task automatic test_underflow();
    redirect_to(32'h500);
    ret = 1; step(); ret = 0;
    checks++; if (pc !== 32'h504) begin errors++; $display("FAIL unf_pc: got %h want %h", pc, 32'h504); end
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b want 1", ras_underflow); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL unf_empty: got %b want 1", ras_empty); end
    step();
    checks++; if (ras_underflow !== 1'b0 || pc !== 32'h508) begin errors++;
      $display("FAIL unf_clear: got unf=%b pc=%h want 0 508", ras_underflow, pc); end
  endtask

  task automatic test_branch();
    redirect_to(32'h600);
    branch = 1; branch_target = 32'h7000; step(); branch = 0;
    checks++; if (pc !== 32'h7000 || ras_empty !== 1'b1) begin errors++;
      $display("FAIL branch: got pc=%h empty=%b want 7000 1", pc, ras_empty); end
  endtask

  task automatic test_wrap_async_reset();
    redirect_to(32'hFFFF_FFFC);
    checks++; if (pc_plus !== 32'h0) begin errors++; $display("FAIL wrap_pcplus: got %h want 0", pc_plus); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc); end
    call = 1; branch_target = 32'h3000; step();
    checks++; if (pc !== 32'h3000 || ras_empty !== 1'b0) begin errors++;
      $display("FAIL pre_reset_call: got pc=%h empty=%b want 3000 0", pc, ras_empty); end
    // Call stays asserted; reset lands between edges.
    @(negedge clk); #1 rst = 0; #1;
    checks++; if (pc !== 32'h100 || ras_empty !== 1'b1) begin errors++;
      $display("FAIL async_reset: got pc=%h empty=%b want 100 1", pc, ras_empty); end
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_hold: got %h want 100", pc); end
    call = 0;
    @(negedge clk); rst = 1;
    step();
    checks++; if (pc !== 32'h104 || ras_empty !== 1'b1) begin errors++;
      $display("FAIL post_reset: got pc=%h empty=%b want 104 1", pc, ras_empty); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_branch();
    test_wrap_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
